// File: rtl/sequenciador_ula.sv
// rtl/sequenciador_ula.sv - command-level sequencer for the 8-bit ALU
//
// Takes one command at a time (opcode + two operands) over an inicio/pronto
// handshake. soma, sub, and, or, xor, not and div-by-zero finish on the
// accept edge. multi (shift-add) and div (restoring) take LARGURA iteration
// cycles. Each result is registered together with its flags, and
// resultado_valido pulses for one cycle.
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   inicio / pronto        command valid / ready (pronto high only in IDLE)
//   Op, A, B               opcode and operands, captured on the accept edge
//   resultado              low word / quotient
//   resultado_alto         product high word / remainder / A on div0 / 0
//   resultado_valido       one-cycle pulse when a result is written
//   ocupado                high while iterating in MUL or DIV
//   flag_zero, flag_carry, flag_overflow, flag_neg, erro_div0  result status
module sequenciador_ula #(
    parameter int LARGURA = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inicio,
    output logic               pronto,
    input  logic [2:0]         Op,
    input  logic [LARGURA-1:0] A,
    input  logic [LARGURA-1:0] B,
    output logic [LARGURA-1:0] resultado,
    output logic [LARGURA-1:0] resultado_alto,
    output logic               resultado_valido,
    output logic               ocupado,
    output logic               flag_zero,
    output logic               flag_carry,
    output logic               flag_overflow,
    output logic               flag_neg,
    output logic               erro_div0
);
    localparam int W  = LARGURA;
    localparam int CW = $clog2(LARGURA) + 1;

    typedef enum logic [1:0] {IDLE, MUL, DIV} estado_t;

    estado_t estado, prox_estado;

    logic [7:0]    op_oh;
    logic [CW-1:0] cont;
    logic          ultima;

    // Multiply: multiplicand shifts left in a double-width register, the
    // multiplier shifts right, so bit 0 of the multiplier selects each add.
    logic [2*W-1:0] acc, mcand, acc_prox;
    logic [W-1:0]   mplier;

    // Divide: the dividend shifts out of quoc from the top while quotient
    // bits shift in from the bottom.
    logic [W-1:0] resto, quoc, divisor, resto_prox, quoc_prox;
    logic [W:0]   resto_desl, resto_sub;
    logic         cabe;

    // Single-cycle datapath and write-back selection
    logic [W:0]   soma_ext, sub_ext;
    logic         unico;
    logic         wr_en, wr_c, wr_v, wr_e;
    logic [W-1:0] wr_lo, wr_hi;

    assign op_oh   = 8'b1 << Op;
    assign pronto  = (estado == IDLE);
    assign ocupado = (estado != IDLE);
    assign ultima  = (cont == CW'(W - 1));

    assign soma_ext = {1'b0, A} + {1'b0, B};
    assign sub_ext  = {1'b0, A} - {1'b0, B};

    assign acc_prox = mplier[0] ? acc + mcand : acc;

    assign resto_desl = {resto, quoc[W-1]};
    assign cabe       = (resto_desl >= {1'b0, divisor});
    assign resto_sub  = resto_desl - {1'b0, divisor};
    assign resto_prox = cabe ? resto_sub[W-1:0] : resto_desl[W-1:0];
    assign quoc_prox  = {quoc[W-2:0], cabe};

    // Everything except multi and div with a non-zero divisor completes
    // on the accept edge.
    assign unico = ~(op_oh[2] | (op_oh[3] & (B != '0)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado <= IDLE;
        end else begin
            estado <= prox_estado;
        end
    end

    always_comb begin
        prox_estado = estado;
        wr_en = 1'b0;
        wr_lo = '0;
        wr_hi = '0;
        wr_c  = 1'b0;
        wr_v  = 1'b0;
        wr_e  = 1'b0;
        case (estado)
            IDLE: begin
                if (inicio) begin
                    if (op_oh[2]) begin
                        prox_estado = MUL;
                    end else if (op_oh[3] && (B != '0)) begin
                        prox_estado = DIV;
                    end
                    wr_en = unico;
                    if (op_oh[0]) begin
                        wr_lo = soma_ext[W-1:0];
                        wr_c  = soma_ext[W];
                        wr_v  = (A[W-1] == B[W-1]) && (soma_ext[W-1] != A[W-1]);
                    end
                    if (op_oh[1]) begin
                        wr_lo = sub_ext[W-1:0];
                        wr_c  = sub_ext[W];
                        wr_v  = (A[W-1] != B[W-1]) && (sub_ext[W-1] != A[W-1]);
                    end
                    if (op_oh[3]) begin
                        wr_lo = '1;
                        wr_hi = A;
                        wr_e  = 1'b1;
                    end
                    if (op_oh[4]) wr_lo = A & B;
                    if (op_oh[5]) wr_lo = A | B;
                    if (op_oh[6]) wr_lo = A ^ B;
                    if (op_oh[7]) wr_lo = ~A;
                end
            end
            MUL: begin
                if (ultima) begin
                    prox_estado = IDLE;
                    wr_en = 1'b1;
                    wr_lo = acc_prox[W-1:0];
                    wr_hi = acc_prox[2*W-1:W];
                    wr_v  = |acc_prox[2*W-1:W];
                end
            end
            DIV: begin
                if (ultima) begin
                    prox_estado = IDLE;
                    wr_en = 1'b1;
                    wr_lo = quoc_prox;
                    wr_hi = resto_prox;
                end
            end
            default: prox_estado = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cont             <= '0;
            acc              <= '0;
            mcand            <= '0;
            mplier           <= '0;
            resto            <= '0;
            quoc             <= '0;
            divisor          <= '0;
            resultado        <= '0;
            resultado_alto   <= '0;
            resultado_valido <= 1'b0;
            flag_zero        <= 1'b0;
            flag_carry       <= 1'b0;
            flag_overflow    <= 1'b0;
            flag_neg         <= 1'b0;
            erro_div0        <= 1'b0;
        end else begin
            resultado_valido <= wr_en;
            if (wr_en) begin
                resultado      <= wr_lo;
                resultado_alto <= wr_hi;
                flag_zero      <= ~|{wr_hi, wr_lo};
                flag_carry     <= wr_c;
                flag_overflow  <= wr_v;
                flag_neg       <= wr_lo[W-1];
                erro_div0      <= wr_e;
            end
            case (estado)
                IDLE: begin
                    // Iteration state is (re)loaded on every accept; it is
                    // only consumed when the FSM moves to MUL or DIV.
                    if (inicio) begin
                        cont    <= '0;
                        acc     <= '0;
                        mcand   <= {{W{1'b0}}, A};
                        mplier  <= B;
                        resto   <= '0;
                        quoc    <= A;
                        divisor <= B;
                    end
                end
                MUL: begin
                    acc    <= acc_prox;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cont   <= ultima ? '0 : cont + CW'(1);
                end
                DIV: begin
                    resto <= resto_prox;
                    quoc  <= quoc_prox;
                    cont  <= ultima ? '0 : cont + CW'(1);
                end
                default: cont <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_sequenciador_ula.sv
// tb/tb_sequenciador_ula.sv - self-checking bench for sequenciador_ula
module tb_sequenciador_ula;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       inicio = 1'b0;
    logic       pronto;
    logic [2:0] Op = 3'd0;
    logic [7:0] A = 8'd0;
    logic [7:0] B = 8'd0;
    logic [7:0] resultado, resultado_alto;
    logic       resultado_valido, ocupado;
    logic       flag_zero, flag_carry, flag_overflow, flag_neg, erro_div0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    sequenciador_ula #(.LARGURA(8)) dut (
        .clk(clk), .rst_n(rst_n), .inicio(inicio), .pronto(pronto),
        .Op(Op), .A(A), .B(B),
        .resultado(resultado), .resultado_alto(resultado_alto),
        .resultado_valido(resultado_valido), .ocupado(ocupado),
        .flag_zero(flag_zero), .flag_carry(flag_carry),
        .flag_overflow(flag_overflow), .flag_neg(flag_neg),
        .erro_div0(erro_div0)
    );

    // {resultado, resultado_alto, carry, overflow, zero, neg, erro_div0}
    function automatic logic [20:0] pack_out();
        return {resultado, resultado_alto, flag_carry, flag_overflow,
                flag_zero, flag_neg, erro_div0};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    // Reference model straight from the arithmetic definitions of each op.
    function automatic void model(input int op, input int a, input int b,
                                  output logic [20:0] exp, output int lat);
        int lo, hi, sa, sb, sr;
        logic c, v, e;
        lo = 0; hi = 0; c = 0; v = 0; e = 0; lat = 0;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        case (op)
            0: begin
                lo = (a + b) % 256; c = (a + b) > 255;
                sr = sa + sb; v = (sr > 127) || (sr < -128);
            end
            1: begin
                lo = (a - b + 256) % 256; c = a < b;
                sr = sa - sb; v = (sr > 127) || (sr < -128);
            end
            2: begin
                lo = (a * b) % 256; hi = (a * b) / 256; v = (hi != 0); lat = 8;
            end
            3: begin
                if (b == 0) begin
                    lo = 255; hi = a; e = 1;
                end else begin
                    lo = a / b; hi = a % b; lat = 8;
                end
            end
            4: lo = a & b;
            5: lo = a | b;
            6: lo = a ^ b;
            default: lo = 255 - a;
        endcase
        exp = {lo[7:0], hi[7:0], c, v, (lo == 0 && hi == 0), (lo >= 128), e};
    endfunction

    // Issue one command from IDLE and check result, latency and pulse width.
    task automatic run_op(input string nm, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [20:0] exp, input int lat);
        int k;
        bit done;
        @(negedge clk);
        inicio = 1'b1; Op = op; A = a; B = b;
        @(posedge clk);
        #1 inicio = 1'b0;
        k = 0; done = 0;
        while (!done && k < 20) begin
            @(negedge clk);
            if (resultado_valido) done = 1;
            else k++;
        end
        chk({nm, "_latency"}, k, lat);
        chk(nm, pack_out(), exp);
        @(negedge clk);
        chk({nm, "_pulse"}, resultado_valido, 1'b0);
    endtask

    typedef struct {
        string      nm;
        logic [2:0] op;
        logic [7:0] a, b;
        logic [7:0] lo, hi;
        logic [4:0] fl;   // carry, overflow, zero, neg, erro_div0
        int         lat;
    } vec_t;

    vec_t tab[11];
    logic [2:0]  bb_op[4];
    logic [7:0]  bb_exp[4];
    logic [20:0] e_r;
    int          l_r, nval;
    logic [7:0]  ra, rb;
    logic [2:0]  rop;

    initial begin
        tab[0]  = '{"soma_200_100", 3'd0, 8'd200, 8'd100, 8'd44,  8'd0,   5'b10000, 0};
        tab[1]  = '{"sub_5_10",     3'd1, 8'd5,   8'd10,  8'd251, 8'd0,   5'b10010, 0};
        tab[2]  = '{"soma_100_100", 3'd0, 8'd100, 8'd100, 8'd200, 8'd0,   5'b01010, 0};
        tab[3]  = '{"mul_255_255",  3'd2, 8'd255, 8'd255, 8'h01,  8'hFE,  5'b01000, 8};
        tab[4]  = '{"div_200_7",    3'd3, 8'd200, 8'd7,   8'd28,  8'd4,   5'b00000, 8};
        tab[5]  = '{"div_9_0",      3'd3, 8'd9,   8'd0,   8'hFF,  8'd9,   5'b00011, 0};
        tab[6]  = '{"sub_80_1",     3'd1, 8'h80,  8'h01,  8'h7F,  8'd0,   5'b01000, 0};
        tab[7]  = '{"soma_0_0",     3'd0, 8'd0,   8'd0,   8'd0,   8'd0,   5'b00100, 0};
        tab[8]  = '{"mul_0_77",     3'd2, 8'd0,   8'd77,  8'd0,   8'd0,   5'b00100, 8};
        tab[9]  = '{"div_5_9",      3'd3, 8'd5,   8'd9,   8'd0,   8'd5,   5'b00000, 8};
        tab[10] = '{"not_ff",       3'd7, 8'hFF,  8'h12,  8'd0,   8'd0,   5'b00100, 0};

        // Reset state
        #1;
        chk("rst_out", pack_out(), 21'd0);
        chk("rst_pronto", pronto, 1'b1);
        chk("rst_ctl", {resultado_valido, ocupado}, 2'b00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++)
            run_op(tab[i].nm, tab[i].op, tab[i].a, tab[i].b,
                   {tab[i].lo, tab[i].hi, tab[i].fl}, tab[i].lat);

        // Back-to-back logic ops, one per cycle
        bb_op  = '{3'd4, 3'd5, 3'd6, 3'd7};
        bb_exp = '{8'h30, 8'hFC, 8'hCC, 8'h0F};
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                chk($sformatf("b2b_res%0d", i - 1), resultado, bb_exp[i - 1]);
                chk($sformatf("b2b_vld%0d", i - 1), {resultado_valido, pronto}, 2'b11);
            end
            if (i < 4) begin
                inicio = 1'b1; Op = bb_op[i]; A = 8'hF0; B = 8'h3C;
            end else begin
                inicio = 1'b0;
            end
            @(negedge clk);
        end

        // Multiply with inicio pulsed mid-operation
        inicio = 1'b1; Op = 3'd2; A = 8'd255; B = 8'd255;
        @(negedge clk);
        inicio = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("mul_busy%0d", k), {ocupado, pronto, resultado_valido}, 3'b100);
            if (k == 3) begin
                inicio = 1'b1; Op = 3'd0; A = 8'd1; B = 8'd1;
            end else begin
                inicio = 1'b0;
            end
            @(negedge clk);
        end
        chk("mul_mid_done", {resultado_valido, pronto, ocupado}, 3'b110);
        chk("mul_mid_res", {resultado, resultado_alto, flag_overflow}, {8'h01, 8'hFE, 1'b1});
        nval = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (resultado_valido) nval++;
        end
        chk("mul_mid_extra_valid", nval, 0);

        // Reset during multiply iteration 4
        inicio = 1'b1; Op = 3'd2; A = 8'd13; B = 8'd11;
        @(negedge clk);
        inicio = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out", pack_out(), 21'd0);
        chk("rst_mid_ctl", {pronto, ocupado, resultado_valido}, 3'b100);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nval = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (resultado_valido) nval++;
        end
        chk("rst_mid_stale", nval, 0);
        chk("rst_mid_hold", pack_out(), 21'd0);
        run_op("post_rst_soma", 3'd0, 8'd0, 8'd0, {8'd0, 8'd0, 5'b00100}, 0);

        // Randomized commands against the reference model
        for (int i = 0; i < 150; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = 8'($urandom);
            rb  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            model(int'(rop), int'(ra), int'(rb), e_r, l_r);
            run_op($sformatf("rnd%0d_op%0d_%0d_%0d", i, rop, ra, rb), rop, ra, rb, e_r, l_r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end
endmodule
